// File: rtl/cpu_pkg.sv
// Constants shared by the CPU front end: default datapath width, the halt
// sentinel and the all-zero NOP word.
package cpu_pkg;

    localparam int unsigned        CPU_XLEN      = 32;
    localparam logic [CPU_XLEN-1:0] CPU_HALT_WORD = '1;
    localparam logic [CPU_XLEN-1:0] CPU_NOP       = '0;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two instruction queue with a registered head entry, so the
// consumer always reads a flop rather than the storage array.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    input  logic                      pop,
    input  logic                      flush,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic [WIDTH-1:0]          head
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_next;
    logic             w_head_from_push;

    assign w_pop     = pop && (r_count != '0);
    assign w_push    = push && (r_count != CW'(DEPTH));
    assign w_rd_next = r_rd_ptr + AW'(1);

    // New data becomes head when it lands in an empty queue or replaces the
    // only entry being popped in the same cycle.
    assign w_head_from_push = w_push &&
                              ((r_count == '0) || (w_pop && (r_count == CW'(1))));

    always_ff @(posedge clk) begin
        if (w_push && reset && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= WIDTH'(CPU_NOP);
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_head_from_push) begin
                r_head <= push_data;
            end else if (w_pop && (r_count > CW'(1))) begin
                r_head <= r_mem[w_rd_next];
            end
        end
    end

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign head  = r_head;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch front end: credit-limited fetch issue, PC sequencing,
// redirect flush and halt-word detection in front of a small queue.
module if_prefetch
    import cpu_pkg::*;
#(
    parameter int unsigned      XLEN      = CPU_XLEN,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [XLEN-1:0]  HALT_WORD = XLEN'(CPU_HALT_WORD)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc4,
    output logic             halted
);

    localparam int unsigned CW = cnt_width(DEPTH);

    logic [XLEN-1:0]   r_fetch_pc;
    logic [XLEN-1:0]   r_inflight_addr;
    logic              r_inflight;
    logic              r_halted;

    logic [XLEN-1:0]   w_addr;
    logic [CW:0]       w_used;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_ret_valid;
    logic              w_ret_halt;
    logic              w_push;
    logic              w_pop;
    logic              w_out_valid;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [2*XLEN-1:0] w_head;
    logic [2*XLEN-1:0] w_push_data;

    // Queued entries plus the outstanding fetch must leave room for one more.
    assign w_used      = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit_ok = (w_used < (CW+1)'(DEPTH));

    // A redirect always issues: the queue and any returning word are dropped
    // at this edge, so credit is guaranteed.
    assign w_issue = reset && (redirect_valid || (!r_halted && w_credit_ok));
    assign w_addr  = redirect_valid ? redirect_pc : r_fetch_pc;

    assign w_ret_valid = reset && r_inflight && !redirect_valid && !r_halted;
    assign w_ret_halt  = w_ret_valid && (imem_rdata == HALT_WORD);
    assign w_push      = w_ret_valid && !w_ret_halt && !w_full;
    assign w_push_data = {imem_rdata, r_inflight_addr + XLEN'(1)};

    assign w_out_valid = reset && !w_empty && !redirect_valid;
    assign w_pop       = w_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_fetch_pc      <= RESET_PC;
            r_inflight      <= 1'b0;
            r_inflight_addr <= '0;
            r_halted        <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_addr <= w_addr;
                r_fetch_pc      <= w_addr + XLEN'(1);
            end
            if (redirect_valid) begin
                r_halted <= 1'b0;
            end else if (w_ret_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (redirect_valid),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head      (w_head)
    );

    assign imem_req  = w_issue;
    assign imem_addr = reset ? w_addr : '0;
    assign out_valid = w_out_valid;
    assign out_instr = reset ? w_head[2*XLEN-1:XLEN] : XLEN'(CPU_NOP);
    assign out_pc4   = reset ? w_head[XLEN-1:0] : '0;
    assign halted    = reset && r_halted;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed and randomized checks of if_prefetch against a queue-based
// reference model, plus a narrow-PC instance exercising address wrap.
module tb_if_prefetch;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
    localparam logic [31:0] FAR   = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc4;
    logic        halted;

    logic        redirect8;
    logic [7:0]  pc8;
    logic        req8;
    logic [7:0]  addr8;
    logic [7:0]  rdata8;
    logic        valid8;
    logic [7:0]  instr8;
    logic [7:0]  pc48;
    logic        halted8;

    int          n_assert;
    int          n_fail;
    int          n_issue;

    ent_t        mq[$];
    ent_t        m_last;
    logic [31:0] m_fetch_pc;
    logic [31:0] m_infl_addr;
    bit          m_infl;
    bit          m_halted;
    logic [31:0] rdata_drv;
    logic [31:0] halt_addr;

    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc4;
    logic        s_halted;
    logic        s_req8;
    logic [7:0]  s_addr8;

    bit          rec8;
    logic [7:0]  q8a[$];
    logic [15:0] q8o[$];

    if_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc4        (out_pc4),
        .halted         (halted)
    );

    if_prefetch #(.XLEN(8), .DEPTH(DEPTH), .RESET_PC(8'h0)) dut8 (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect8),
        .redirect_pc    (pc8),
        .imem_req       (req8),
        .imem_addr      (addr8),
        .imem_rdata     (rdata8),
        .out_valid      (valid8),
        .out_ready      (1'b1),
        .out_instr      (instr8),
        .out_pc4        (pc48),
        .halted         (halted8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == halt_addr) ? HALTW : a + 32'h100;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample and check at the falling edge, advance the
    // model, then return memory data one cycle after each request.
    task automatic step();
        bit          exp_req;
        bit          exp_valid;
        logic [31:0] exp_addr;
        ent_t        shown;
        ent_t        e;
        @(negedge clk);
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_valid  = out_valid;
        s_instr  = out_instr;
        s_pc4    = out_pc4;
        s_halted = halted;
        s_req8   = req8;
        s_addr8  = addr8;
        if (imem_req) n_issue++;
        if (rec8) begin
            if (req8) q8a.push_back(addr8);
            if (valid8) q8o.push_back({instr8, pc48});
        end
        if (!reset) begin
            check("rst_req", 64'(imem_req), 64'd0);
            check("rst_valid", 64'(out_valid), 64'd0);
            check("rst_halted", 64'(halted), 64'd0);
            check("rst_instr", 64'(out_instr), 64'd0);
            check("rst_pc4", 64'(out_pc4), 64'd0);
            mq.delete();
            m_last     = '0;
            m_fetch_pc = 32'h0;
            m_halted   = 1'b0;
            m_infl     = 1'b0;
        end else begin
            exp_req  = redirect_valid || (!m_halted && ((mq.size() + int'(m_infl)) < DEPTH));
            exp_addr = redirect_valid ? redirect_pc : m_fetch_pc;
            check("req", 64'(imem_req), 64'(exp_req));
            if (exp_req) check("addr", 64'(imem_addr), 64'(exp_addr));
            exp_valid = (mq.size() > 0) && !redirect_valid;
            check("valid", 64'(out_valid), 64'(exp_valid));
            check("halted", 64'(halted), 64'(m_halted));
            shown = (mq.size() > 0) ? mq[0] : m_last;
            check("instr", 64'(out_instr), 64'(shown.instr));
            check("pc4", 64'(out_pc4), 64'(shown.pc4));
            m_last = shown;
            if (redirect_valid) begin
                mq.delete();
                m_halted = 1'b0;
            end else begin
                if (exp_valid && out_ready) void'(mq.pop_front());
                if (m_infl && !m_halted) begin
                    if (rdata_drv == HALTW) begin
                        m_halted = 1'b1;
                    end else begin
                        e.instr = rdata_drv;
                        e.pc4   = m_infl_addr + 32'd1;
                        mq.push_back(e);
                    end
                end
            end
            m_infl = exp_req;
            if (exp_req) begin
                m_infl_addr = exp_addr;
                m_fetch_pc  = exp_addr + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        rdata_drv  = s_req ? mem(s_addr) : ($urandom & 32'h7FFF_FFFF);
        imem_rdata = rdata_drv;
        rdata8     = s_req8 ? (s_addr8 ^ 8'h5A) : 8'(($urandom & 32'h7F));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        bit found;
        n_assert = 0;
        n_fail = 0;
        n_issue = 0;
        reset = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b1;
        imem_rdata = '0;
        rdata_drv = '0;
        halt_addr = FAR;
        redirect8 = 1'b0;
        pc8 = '0;
        rdata8 = '0;
        rec8 = 1'b0;
        mq.delete();
        m_last = '0;
        m_fetch_pc = '0;
        m_infl_addr = '0;
        m_infl = 1'b0;
        m_halted = 1'b0;

        // Streaming from reset: first word visible in cycle 2.
        do_reset();
        out_ready = 1'b1;
        step();
        step();
        step();
        check("first_valid", 64'(s_valid), 64'd1);
        check("first_instr", 64'(s_instr), 64'h100);
        check("first_pc4", 64'(s_pc4), 64'd1);
        step();
        check("second_instr", 64'(s_instr), 64'h101);
        check("second_pc4", 64'(s_pc4), 64'd2);
        repeat (8) step();

        // Stall from reset: only DEPTH fetches go out.
        do_reset();
        out_ready = 1'b0;
        n_issue = 0;
        repeat (10) step();
        check("stall_issues", 64'(n_issue), 64'(DEPTH));
        check("stall_req", 64'(s_req), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("drain_valid", 64'(s_valid), 64'd1);
            check("drain_instr", 64'(s_instr), 64'(32'h100 + k));
        end
        repeat (4) step();

        // Redirect with three entries queued.
        do_reset();
        out_ready = 1'b0;
        repeat (4) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        check("redir_valid0", 64'(s_valid), 64'd0);
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        check("redir_seen", 64'(found), 64'd1);
        check("redir_instr", 64'(s_instr), 64'h140);
        check("redir_pc4", 64'(s_pc4), 64'h41);
        repeat (4) step();

        // Halt word at address 5, then recovery by redirect.
        halt_addr = 32'd5;
        do_reset();
        out_ready = 1'b1;
        repeat (12) step();
        check("halt_set", 64'(s_halted), 64'd1);
        n_issue = 0;
        repeat (20) step();
        check("halt_noissue", 64'(n_issue), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        step();
        redirect_valid = 1'b0;
        step();
        check("halt_clear", 64'(s_halted), 64'd0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        check("halt_resume_seen", 64'(found), 64'd1);
        check("halt_resume_instr", 64'(s_instr), 64'h110);
        halt_addr = FAR;
        repeat (4) step();

        // Reset with a full queue.
        out_ready = 1'b0;
        repeat (8) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("rel_req", 64'(s_req), 64'd1);
        check("rel_addr", 64'(s_addr), 64'h0);
        out_ready = 1'b1;
        repeat (4) step();

        // Randomized traffic against the model.
        halt_addr = 32'h37;
        for (int k = 0; k < 600; k++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = reset && ($urandom_range(0, 19) == 0);
            redirect_pc    = 32'($urandom_range(0, 255));
            reset          = ($urandom_range(0, 199) != 0);
            if (!reset) redirect_valid = 1'b0;
            step();
        end
        reset = 1'b1;
        redirect_valid = 1'b0;
        halt_addr = FAR;

        // Narrow PC: redirect to 0xFE and watch the wrap.
        out_ready = 1'b1;
        do_reset();
        rec8 = 1'b1;
        q8a.delete();
        q8o.delete();
        redirect8 = 1'b1;
        pc8 = 8'hFE;
        step();
        redirect8 = 1'b0;
        repeat (8) step();
        rec8 = 1'b0;
        check("w8_naddr", 64'(q8a.size() >= 3), 64'd1);
        check("w8_addr0", 64'(q8a[0]), 64'hFE);
        check("w8_addr1", 64'(q8a[1]), 64'hFF);
        check("w8_addr2", 64'(q8a[2]), 64'h00);
        check("w8_nout", 64'(q8o.size() >= 3), 64'd1);
        check("w8_out0", 64'(q8o[0]), 64'hA4FF);
        check("w8_out1", 64'(q8o[1]), 64'hA500);
        check("w8_out2", 64'(q8o[2]), 64'h5A01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
